// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the multicycle control FSM. It holds a
//   single-port, word-organised instruction+data RAM with a fixed access
//   latency. Completion is signalled to the requester with a one-cycle
//   mem_ready pulse.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset (RAM contents are preserved)
//   MemRead    read request level, held by the requester until mem_ready
//   MemWrite   write request level, held by the requester until mem_ready;
//              wins over MemRead when both are high
//   Address    byte address; the word index is Address[ADDR_W+1:2]
//   WriteData  store data
//   MemData    registered read data; holds until the next successful read
//   mem_ready  one-cycle completion pulse
//   busy       high whenever the FSM is not in IDLE
//   misaligned one-cycle pulse alongside mem_ready when Address[1:0] != 0
//
// States
//   state | meaning
//   IDLE  | waiting for a request; inputs are sampled only here
//   BUSY  | latency countdown; the access happens when cnt reaches 0
//   RESP  | mem_ready (and possibly misaligned) high for this one cycle
// ---------------------------------------------------------------------------
module mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       Address,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] MemData,
  output logic              mem_ready,
  output logic              busy,
  output logic              misaligned
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] idx_q;
  logic [DATA_W-1:0] data_q;
  logic              wr_q;
  logic              mis_q;
  logic              ram_we;

  // RAM powers up cleared; reset deliberately leaves it alone.
  logic [DATA_W-1:0] ram [DEPTH] = '{default: '0};

  // Upper address bits only alias onto the same words.
  logic unused_addr;
  assign unused_addr = ^Address[31:ADDR_W+2];

  // Write fires on the final BUSY edge; a reset on that edge aborts it.
  assign ram_we = !reset && (state == BUSY) && (cnt == '0) && wr_q && !mis_q;

  always_ff @(posedge clk) begin
    if (ram_we) ram[idx_q] <= data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      mem_ready  <= 1'b0;
      misaligned <= 1'b0;
      MemData    <= '0;
    end else begin
      mem_ready  <= 1'b0;
      misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (MemRead || MemWrite) begin
            idx_q  <= Address[ADDR_W+1:2];
            data_q <= WriteData;
            wr_q   <= MemWrite;
            mis_q  <= (Address[1:0] != 2'b00);
            cnt    <= CNT_W'(LATENCY - 1);
            busy   <= 1'b1;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            if (!wr_q && !mis_q) MemData <= ram[idx_q];
            mem_ready  <= 1'b1;
            misaligned <= mis_q;
            state      <= RESP;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [31:0] Address, WriteData;
  logic [31:0] MemData;
  logic        mem_ready, busy, misaligned;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        mis;
    int          ready_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [256];
  logic [31:0] last_md;

  mem_responder #(.ADDR_W(8), .DATA_W(32), .LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Address   (Address),
    .WriteData (WriteData),
    .MemData   (MemData),
    .mem_ready (mem_ready),
    .busy      (busy),
    .misaligned(misaligned)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Response monitor: every mem_ready pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (mem_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, "_latency"}, cyc, e.ready_cyc);
        chk({e.tag, "_data"}, MemData, e.data);
        chk({e.tag, "_mis"}, {31'd0, misaligned}, {31'd0, e.mis});
      end
    end
  end

  // Drive one request at a negedge; it is accepted on the next posedge.
  task automatic do_req(input string tag, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    int   idx;
    bit   seen;
    @(negedge clk);
    idx = int'(addr[9:2]);
    e.tag = tag;
    e.mis = (addr[1:0] != 2'b00);
    if (wr) begin
      if (!e.mis) model[idx] = data;
    end else if (rd && !e.mis) begin
      last_md = model[idx];
    end
    e.data      = last_md;
    e.ready_cyc = cyc + 1 + LAT;
    sb.push_back(e);
    MemRead = rd; MemWrite = wr; Address = addr; WriteData = data;
    @(negedge clk);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    // Post-acceptance changes must be ignored.
    Address   = addr ^ 32'h0000_00F4;
    WriteData = ~data;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (mem_ready) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    MemRead = 1'b0; MemWrite = 1'b0;
    if (!seen) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
      sb.delete();
    end else begin
      @(negedge clk);
      chk({tag, "_pulse_width"}, {31'd0, mem_ready}, 32'd0);
      chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model[i] = '0;
    last_md = '0;
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Address = '0; WriteData = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_memdata", MemData, 32'd0);
    chk("rst_ready", {31'd0, mem_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mis", {31'd0, misaligned}, 32'd0);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_busy", {31'd0, busy}, 32'd0);
    end

    do_req("wr10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    do_req("rd10", 1'b1, 1'b0, 32'h10, 32'h0);
    do_req("wr13_mis", 1'b0, 1'b1, 32'h13, 32'h12345678);
    do_req("rd10_again", 1'b1, 1'b0, 32'h10, 32'h0);
    do_req("rd12_mis", 1'b1, 1'b0, 32'h12, 32'h0);
    do_req("rdwr20", 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5);
    do_req("rd20", 1'b1, 1'b0, 32'h20, 32'h0);

    // Reset during BUSY aborts the write.
    @(negedge clk);
    MemWrite = 1'b1; Address = 32'h30; WriteData = 32'h0BADF00D;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1; MemWrite = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy_clr", {31'd0, busy}, 32'd0);
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_ready", {31'd0, mem_ready}, 32'd0);
    end
    last_md = '0;
    do_req("rd30", 1'b1, 1'b0, 32'h30, 32'h0);

    do_req("wr400", 1'b0, 1'b1, 32'h400, 32'h11112222);
    do_req("rd000_alias", 1'b1, 1'b0, 32'h000, 32'h0);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      logic        w;
      a = $urandom_range(0, 32'hFFF);
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      a[9:8] = 2'b00;
      w = ($urandom_range(0, 1) == 1);
      do_req(w ? "rnd_wr" : "rnd_rd", !w, w, a, $urandom);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
